cpu_run_ctrl: RTL and testbench
===============================

// Module: cpu_run_ctrl
// PURPOSE
//   Parametrised run controller for the single-cycle MIPS CPU bench: sequences the CPU reset,
//   counts executed cycles and register write-backs, and ends the run on halt or timeout.
//   Halt means the PC is unchanged for STALL_LIMIT consecutive cycles (a self-loop end idiom).
//   Sits between the bench clock/reset and the CPU; replaces fixed-delay free-running benches.
// PARAMETERS
//   PC_W        32          width of observed PC and final_pc
//   CNT_W       32          width of cycle_cnt / wb_cnt
//   RST_CYCLES  4           cycles cpu_reset is held high after start (>=1)
//   STALL_LIMIT 8           consecutive equal-PC comparisons that declare halt (>=1)
//   MAX_CYCLES  100000      RUN-cycle budget before timeout (>=1, < 2**CNT_W)
// PORTS
//   clk        in   1      bench clock, all state on rising edge
//   reset      in   1      asynchronous, active-low reset of this block
//   start      in   1      level-sampled; high in IDLE or DONE launches a run
//   pc         in   PC_W   CPU current PC
//   reg_we     in   1      CPU GRF write enable (write-back this cycle)
//   cpu_reset  out  1      active-high synchronous reset driven to the CPU
//   running    out  1      high while in RUN
//   done       out  1      high in DONE (run finished)
//   timeout    out  1      high in DONE when the run ended on MAX_CYCLES, not halt
//   cycle_cnt  out  CNT_W  RUN cycles elapsed this run
//   wb_cnt     out  CNT_W  RUN cycles with reg_we=1 this run, saturating at all-ones
//   final_pc   out  PC_W   PC captured at end of run
// BEHAVIOUR
//   - States: IDLE, RESET, RUN, DONE. reset=0 (async) -> IDLE; cpu_reset=1, running=0, done=0,
//     timeout=0, cycle_cnt=0, wb_cnt=0, final_pc=0, rst/stall counters and prev-PC valid cleared.
//   - IDLE: cpu_reset=1. start=1 at an edge -> RESET; clears counters, timeout, final_pc.
//   - RESET: cpu_reset=1 for exactly RST_CYCLES edges (counter), then -> RUN. start ignored.
//   - RUN: cpu_reset=0, running=1. Every edge: cycle_cnt+=1; wb_cnt+=1 if reg_we (saturate);
//     prev_pc<=pc, prev_valid<=1. If prev_valid && pc==prev_pc, stall_cnt+=1, else stall_cnt=0.
//     The first RUN cycle never compares (prev_valid=0). start ignored.
//   - Halt: at the edge where the incremented stall_cnt equals STALL_LIMIT -> DONE, timeout=0.
//   - Timeout: at the edge where the incremented cycle_cnt equals MAX_CYCLES -> DONE, timeout=1.
//   - Halt and timeout on the same edge: halt wins, timeout=0.
//   - On entering DONE: final_pc<=pc, counters include the terminating cycle, then freeze.
//   - DONE: cpu_reset=1 (CPU parked), done=1; outputs held. start=1 -> RESET as from IDLE
//     (counters/timeout/final_pc cleared that edge, done falls next cycle).
//   - Async reset mid-run: immediate return to IDLE values; cpu_reset rises without waiting
//     for clk.
//   - All comparisons full PC_W width; counters unsigned; no X propagation from pc while in
//     IDLE/RESET (pc is not sampled there).
// TESTING
//   1 reset=0 then 1, start=0 for 10 clk -> cpu_reset=1, running=0, done=0, all counts 0.
//   2 RST_CYCLES=4, start pulse 1 cycle -> cpu_reset high 4 edges after start, then low;
//     running rises same edge cpu_reset falls.
//   3 STALL_LIMIT=3, pc=0x3000,0x3004,0x3008,0x3008,0x3008,0x3008 -> DONE at 6th RUN edge,
//     timeout=0, final_pc=0x3008, cycle_cnt=6.
//   4 MAX_CYCLES=20, pc increments by 4 each cycle, reg_we=1 every other cycle -> DONE after
//     20 RUN edges, timeout=1, cycle_cnt=20, wb_cnt=10.
//   5 MAX_CYCLES=6, STALL_LIMIT=3, pc stalls from RUN cycle 3 -> halt and timeout coincide on
//     edge 6 -> timeout=0.
//   6 reset=0 asserted mid-RUN between edges -> cpu_reset=1 and counts 0 immediately; new start
//     after release gives a clean run identical to scenario 3.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_run_ctrl
//  Function : Run controller for the single-cycle MIPS CPU bench. Sequences
//             the CPU reset, counts RUN cycles and register write-backs, and
//             ends the run on halt (PC unchanged for STALL_LIMIT consecutive
//             comparisons) or on a RUN-cycle budget (timeout).
//  Revision : 1.0 - initial release
// ============================================================================
module cpu_run_ctrl #(
  parameter int PC_W        = 32,
  parameter int CNT_W       = 32,
  parameter int RST_CYCLES  = 4,
  parameter int STALL_LIMIT = 8,
  parameter int MAX_CYCLES  = 100000
) (
  input  logic             clk,
  input  logic             reset,      // asynchronous, active-low
  input  logic             start,
  input  logic [PC_W-1:0]  pc,
  input  logic             reg_we,
  output logic             cpu_reset,
  output logic             running,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] wb_cnt,
  output logic [PC_W-1:0]  final_pc
);

  localparam int c_RST_W   = (RST_CYCLES  > 1) ? $clog2(RST_CYCLES + 1)  : 1;
  localparam int c_STALL_W = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT + 1) : 1;

  localparam logic [c_RST_W-1:0]   c_RST_LAST  = c_RST_W'(RST_CYCLES - 1);
  localparam logic [c_STALL_W-1:0] c_STALL_MAX = c_STALL_W'(STALL_LIMIT);
  localparam logic [CNT_W-1:0]     c_CYC_MAX   = CNT_W'(MAX_CYCLES);
  localparam logic [CNT_W-1:0]     c_CNT_ONE   = CNT_W'(1);
  localparam logic [c_STALL_W-1:0] c_STALL_ONE = c_STALL_W'(1);
  localparam logic [c_RST_W-1:0]   c_RST_ONE   = c_RST_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RESET = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  logic [c_RST_W-1:0]    r_rst_cnt;
  logic [c_STALL_W-1:0]  r_stall_cnt;
  logic [PC_W-1:0]       r_prev_pc;
  logic                  r_prev_valid;
  logic                  r_cpu_reset;
  logic                  r_running;
  logic                  r_done;
  logic                  r_timeout;
  logic [CNT_W-1:0]      r_cycle_cnt;
  logic [CNT_W-1:0]      r_wb_cnt;
  logic [PC_W-1:0]       r_final_pc;

  logic [CNT_W-1:0]      w_cyc_next;
  logic [CNT_W-1:0]      w_wb_next;
  logic [c_STALL_W-1:0]  w_stall_next;
  logic                  w_halt;
  logic                  w_budget_hit;

  // Next values of the RUN-phase counters and the two end-of-run conditions
  always_comb begin
    w_cyc_next   = r_cycle_cnt + c_CNT_ONE;
    w_wb_next    = r_wb_cnt;
    w_stall_next = '0;
    if (reg_we && (r_wb_cnt != {CNT_W{1'b1}})) begin
      w_wb_next = r_wb_cnt + c_CNT_ONE;
    end
    // The first RUN cycle has no previous PC, so it never counts as a stall
    if (r_prev_valid && (pc == r_prev_pc)) begin
      w_stall_next = r_stall_cnt + c_STALL_ONE;
    end
    w_halt       = (w_stall_next == c_STALL_MAX);
    w_budget_hit = (w_cyc_next == c_CYC_MAX);
  end

  // Run-control state machine with registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_rst_cnt    <= '0;
      r_stall_cnt  <= '0;
      r_prev_pc    <= '0;
      r_prev_valid <= 1'b0;
      r_cpu_reset  <= 1'b1;
      r_running    <= 1'b0;
      r_done       <= 1'b0;
      r_timeout    <= 1'b0;
      r_cycle_cnt  <= '0;
      r_wb_cnt     <= '0;
      r_final_pc   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state      <= S_RESET;
            r_rst_cnt    <= '0;
            r_stall_cnt  <= '0;
            r_prev_valid <= 1'b0;
            r_cpu_reset  <= 1'b1;
            r_running    <= 1'b0;
            r_done       <= 1'b0;
            r_timeout    <= 1'b0;
            r_cycle_cnt  <= '0;
            r_wb_cnt     <= '0;
            r_final_pc   <= '0;
          end
        end
        S_RESET: begin
          if (r_rst_cnt == c_RST_LAST) begin
            r_state     <= S_RUN;
            r_cpu_reset <= 1'b0;
            r_running   <= 1'b1;
          end else begin
            r_rst_cnt <= r_rst_cnt + c_RST_ONE;
          end
        end
        S_RUN: begin
          r_cycle_cnt  <= w_cyc_next;
          r_wb_cnt     <= w_wb_next;
          r_prev_pc    <= pc;
          r_prev_valid <= 1'b1;
          r_stall_cnt  <= w_stall_next;
          // Halt takes priority when both conditions land on the same edge
          if (w_halt || w_budget_hit) begin
            r_state     <= S_DONE;
            r_cpu_reset <= 1'b1;
            r_running   <= 1'b0;
            r_done      <= 1'b1;
            r_timeout   <= !w_halt;
            r_final_pc  <= pc;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign cpu_reset = r_cpu_reset;
  assign running   = r_running;
  assign done      = r_done;
  assign timeout   = r_timeout;
  assign cycle_cnt = r_cycle_cnt;
  assign wb_cnt    = r_wb_cnt;
  assign final_pc  = r_final_pc;

endmodule
`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu_run_ctrl
//  Function : Self-checking bench for cpu_run_ctrl against a history-based
//             reference model (halt = last STALL_LIMIT+1 PCs equal).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_run_ctrl;

  localparam int RST  = 4;
  localparam int STL  = 3;
  localparam int MAXC = 20;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] pc;
  logic        reg_we;
  logic        cpu_reset;
  logic        running;
  logic        done;
  logic        timeout;
  logic [31:0] cycle_cnt;
  logic [31:0] wb_cnt;
  logic [31:0] final_pc;

  int checks = 0;
  int errors = 0;

  // Reference model state: phase 0 idle, 1 cpu held in reset, 2 running, 3 finished
  int          m_phase;
  int          m_rst_left;
  logic [31:0] m_pcs[$];
  logic [31:0] m_cycles;
  logic [31:0] m_wb;
  logic        m_timeout;
  logic [31:0] m_final;

  cpu_run_ctrl #(
    .PC_W(32), .CNT_W(32), .RST_CYCLES(RST), .STALL_LIMIT(STL), .MAX_CYCLES(MAXC)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pc(pc), .reg_we(reg_we),
    .cpu_reset(cpu_reset), .running(running), .done(done), .timeout(timeout),
    .cycle_cnt(cycle_cnt), .wb_cnt(wb_cnt), .final_pc(final_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_phase = 0; m_rst_left = 0; m_pcs.delete();
    m_cycles = 0; m_wb = 0; m_timeout = 0; m_final = 0;
  endtask

  // One rising edge of the model, using the inputs the DUT sampled
  task automatic m_edge(input logic s, input logic [31:0] p, input logic w);
    bit same;
    int n;
    case (m_phase)
      0, 3: if (s) begin
        m_phase = 1; m_rst_left = RST; m_pcs.delete();
        m_cycles = 0; m_wb = 0; m_timeout = 0; m_final = 0;
      end
      1: begin
        m_rst_left--;
        if (m_rst_left == 0) m_phase = 2;
      end
      2: begin
        m_pcs.push_back(p);
        m_cycles++;
        if (w && m_wb != 32'hFFFF_FFFF) m_wb++;
        n = m_pcs.size();
        same = (n > STL);
        if (same) for (int k = 1; k <= STL; k++) if (m_pcs[n-1-k] !== p) same = 0;
        if (same) begin
          m_phase = 3; m_timeout = 0; m_final = p;
        end else if (m_cycles == MAXC) begin
          m_phase = 3; m_timeout = 1; m_final = p;
        end
      end
      default: m_phase = 0;
    endcase
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".cpu_reset"}, 64'(cpu_reset), 64'(m_phase != 2));
    chk({tag, ".running"},   64'(running),   64'(m_phase == 2));
    chk({tag, ".done"},      64'(done),      64'(m_phase == 3));
    chk({tag, ".timeout"},   64'(timeout),   64'(m_timeout));
    chk({tag, ".cycle_cnt"}, 64'(cycle_cnt), 64'(m_cycles));
    chk({tag, ".wb_cnt"},    64'(wb_cnt),    64'(m_wb));
    chk({tag, ".final_pc"},  64'(final_pc),  64'(m_final));
  endtask

  // Drive inputs, take one edge, update the model, check 1 time unit later
  task automatic step(input string tag, input logic s, input logic [31:0] p, input logic w);
    start = s; pc = p; reg_we = w;
    @(posedge clk);
    m_edge(s, p, w);
    #1;
    check_all(tag);
  endtask

  task automatic launch(input string tag);
    step(tag, 1'b1, 32'hx, 1'b0);
    for (int i = 0; i < RST; i++) step(tag, 1'b0, 32'hx, 1'b0);
  endtask

  task automatic run_halt3(input string tag);
    logic [31:0] seq[6];
    seq = '{32'h3000, 32'h3004, 32'h3008, 32'h3008, 32'h3008, 32'h3008};
    launch(tag);
    for (int i = 0; i < 6; i++) step(tag, 1'b0, seq[i], 1'(i % 2));
    chk({tag, ".halt_done"},  64'(done),      64'd1);
    chk({tag, ".halt_to"},    64'(timeout),   64'd0);
    chk({tag, ".halt_pc"},    64'(final_pc),  64'h3008);
    chk({tag, ".halt_cyc"},   64'(cycle_cnt), 64'd6);
    chk({tag, ".halt_wb"},    64'(wb_cnt),    64'd3);
  endtask

  initial begin
    logic [31:0] lastpc;
    reset = 1'b0; start = 1'b0; pc = 32'h0; reg_we = 1'b0;
    m_reset();
    #12;
    check_all("por");
    #5 reset = 1'b1;

    // Idle with start low: nothing moves
    for (int i = 0; i < 10; i++) step("idle", 1'b0, 32'hx, 1'($urandom % 2));

    // Reset sequencing: cpu_reset held for RST edges, running rises as it falls
    step("rst", 1'b1, 32'hx, 1'b0);
    for (int i = 0; i < RST - 1; i++) begin
      step("rst", 1'($urandom % 2), 32'hx, 1'b0);
      chk("rst.held", 64'(cpu_reset), 64'd1);
    end
    step("rst", 1'b0, 32'hx, 1'b0);
    chk("rst.release", 64'(cpu_reset), 64'd0);
    chk("rst.running", 64'(running), 64'd1);
    // Finish this run by stalling, with start toggling (ignored in RUN)
    for (int i = 0; i < STL + 1; i++) step("rst", 1'($urandom % 2), 32'h0, 1'b0);
    chk("rst.halted", 64'(done), 64'd1);

    // Halt after three equal comparisons (restart from DONE)
    run_halt3("halt");

    // Timeout with incrementing PC and write-back every other cycle
    launch("tmo");
    for (int i = 0; i < MAXC; i++) step("tmo", 1'b0, 32'h1000 + 32'(4 * i), 1'(i % 2 == 0));
    chk("tmo.done", 64'(done), 64'd1);
    chk("tmo.flag", 64'(timeout), 64'd1);
    chk("tmo.cyc",  64'(cycle_cnt), 64'd20);
    chk("tmo.wb",   64'(wb_cnt), 64'd10);
    step("tmo.hold", 1'b0, 32'hdead, 1'b1);
    chk("tmo.hold_cyc", 64'(cycle_cnt), 64'd20);

    // Halt and budget on the same edge: halt wins
    launch("both");
    for (int i = 0; i < MAXC; i++)
      step("both", 1'b0, (i < 16) ? 32'h2000 + 32'(4 * i) : 32'h5000, 1'b0);
    chk("both.done", 64'(done), 64'd1);
    chk("both.to",   64'(timeout), 64'd0);
    chk("both.cyc",  64'(cycle_cnt), 64'd20);
    chk("both.pc",   64'(final_pc), 64'h5000);

    // Asynchronous reset between edges in the middle of a run
    launch("async");
    for (int i = 0; i < 3; i++) step("async", 1'b0, 32'h400 + 32'(4 * i), 1'b1);
    #3 reset = 1'b0;
    #1;
    m_reset();
    chk("async.cpu_reset", 64'(cpu_reset), 64'd1);
    chk("async.running",   64'(running), 64'd0);
    chk("async.cyc",       64'(cycle_cnt), 64'd0);
    chk("async.wb",        64'(wb_cnt), 64'd0);
    #2 reset = 1'b1;
    step("async.idle", 1'b0, 32'hx, 1'b0);
    run_halt3("async.rerun");

    // Randomized runs against the model
    lastpc = 32'h0;
    for (int r = 0; r < 8; r++) begin
      step("rnd", 1'b1, $urandom, 1'($urandom % 2));
      for (int b = 0; b < 60 && m_phase != 3; b++) begin
        if (($urandom % 3) != 0) lastpc = {27'h0, 3'($urandom % 8), 2'b00};
        step("rnd", 1'($urandom % 2), lastpc, 1'($urandom % 2));
      end
      chk("rnd.ended", 64'(done), 64'd1);
      for (int i = 0; i < 2; i++) step("rnd.park", 1'b0, $urandom, 1'($urandom % 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
